// File: rtl/norm_lzc_pipe.sv
// Two-stage mantissa normaliser: leading-zero count in stage 1, shift and exponent adjust in stage 2.
// Optional exponent-underflow clamping and the oUnf flag are enabled by defining NORM_LZC_UNDERFLOW_EN.
module norm_lzc_pipe #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iMant,
  input  logic [EXP_W-1:0] iExp,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oMant,
  output logic [EXP_W-1:0] oExp,
  output logic [CNT_W-1:0] oLzc,
  output logic             oZero
`ifdef NORM_LZC_UNDERFLOW_EN
  ,
  output logic             oUnf
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [CNT_W-1:0] s1_lzc;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;

  assign adv2   = !s2_valid || iReady;
  assign adv1   = !s1_valid || adv2;
  assign oReady = adv1;
  assign oValid = s2_valid;

  // Priority encode from the MSB; all-zero input leaves the count at WIDTH.
  logic [CNT_W-1:0] lzc;
  logic             found;
  always_comb begin
    lzc   = CNT_W'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && iMant[WIDTH-1-i]) begin
        lzc   = CNT_W'(i);
        found = 1'b1;
      end
    end
  end

  // Exponent and count are widened to a common width so the compare and subtract are exact.
  logic [EXP_W+CNT_W-1:0] exp_ext;
  logic [EXP_W+CNT_W-1:0] cnt_ext;
  logic [EXP_W+CNT_W-1:0] diff;
  logic                   zero;
  logic [WIDTH-1:0]       n_mant;
  logic [EXP_W-1:0]       n_exp;
  logic                   n_unf;

  always_comb begin
    exp_ext = {{CNT_W{1'b0}}, s1_exp};
    cnt_ext = {{EXP_W{1'b0}}, s1_lzc};
    diff    = exp_ext - cnt_ext;
    zero    = (s1_lzc == CNT_W'(WIDTH));
    n_mant  = s1_mant << s1_lzc;
    n_exp   = diff[EXP_W-1:0];
    n_unf   = 1'b0;
`ifdef NORM_LZC_UNDERFLOW_EN
    if (!zero && (exp_ext < cnt_ext)) begin
      n_unf  = 1'b1;
      n_exp  = '0;
      n_mant = s1_mant << s1_exp;
    end
`endif
    if (zero) begin
      n_mant = '0;
      n_exp  = '0;
    end
  end

  logic unf_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lzc   <= '0;
      s2_valid <= 1'b0;
      oMant    <= '0;
      oExp     <= '0;
      oLzc     <= '0;
      oZero    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= iValid;
        if (iValid) begin
          s1_mant <= iMant;
          s1_exp  <= iExp;
          s1_lzc  <= lzc;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          oMant <= n_mant;
          oExp  <= n_exp;
          oLzc  <= s1_lzc;
          oZero <= zero;
          unf_q <= n_unf;
        end
      end
    end
  end

`ifdef NORM_LZC_UNDERFLOW_EN
  assign oUnf = unf_q;
`else
  logic unused_unf;
  assign unused_unf = unf_q;
`endif

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// Directed bench for norm_lzc_pipe (WIDTH=24, EXP_W=8); expectations are hand-computed constants.
// Honours NORM_LZC_UNDERFLOW_EN so the same bench checks either build.
module tb_norm_lzc_pipe;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [23:0] iMant;
  logic [7:0]  iExp;
  logic        oValid;
  logic        iReady;
  logic [23:0] oMant;
  logic [7:0]  oExp;
  logic [4:0]  oLzc;
  logic        oZero;
`ifdef NORM_LZC_UNDERFLOW_EN
  logic        oUnf;
`endif

  int errors = 0;
  int checks = 0;

  norm_lzc_pipe #(.WIDTH(24), .EXP_W(8)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iValid(iValid),
    .oReady(oReady),
    .iMant (iMant),
    .iExp  (iExp),
    .oValid(oValid),
    .iReady(iReady),
    .oMant (oMant),
    .oExp  (oExp),
    .oLzc  (oLzc),
    .oZero (oZero)
`ifdef NORM_LZC_UNDERFLOW_EN
    ,
    .oUnf  (oUnf)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_unf(input string tag, input logic xu);
`ifdef NORM_LZC_UNDERFLOW_EN
    chk(tag, 32'(oUnf), 32'(xu));
`else
    if (xu) $display("note: %s expects underflow only with the macro", tag);
`endif
  endtask

  task automatic run_one(input string tag, input logic [23:0] m, input logic [7:0] e,
                         input logic [23:0] xm, input logic [7:0] xe, input logic [4:0] xl,
                         input logic xz, input logic xu);
    iValid = 1'b1;
    iMant  = m;
    iExp   = e;
    step();
    iValid = 1'b0;
    iMant  = '0;
    iExp   = '0;
    chk({tag, "_lat1"}, 32'(oValid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(oValid), 32'd1);
    chk({tag, "_mant"},  32'(oMant),  32'(xm));
    chk({tag, "_exp"},   32'(oExp),   32'(xe));
    chk({tag, "_lzc"},   32'(oLzc),   32'(xl));
    chk({tag, "_zero"},  32'(oZero),  32'(xz));
    chk_unf({tag, "_unf"}, xu);
    step();
    chk({tag, "_drain"}, 32'(oValid), 32'd0);
  endtask

  logic [23:0] in_m [6] = '{24'h800000, 24'h400000, 24'h000F00, 24'h123456, 24'h000003, 24'h0000A5};
  logic [7:0]  in_e [6] = '{8'd20, 8'd20, 8'd30, 8'd40, 8'd100, 8'd60};
  logic [23:0] ex_m [6] = '{24'h800000, 24'h800000, 24'hF00000, 24'h91A2B0, 24'hC00000, 24'hA50000};
  logic [7:0]  ex_e [6] = '{8'd20, 8'd19, 8'd18, 8'd37, 8'd78, 8'd44};
  logic [4:0]  ex_l [6] = '{5'd0, 5'd1, 5'd12, 5'd3, 5'd22, 5'd16};

  initial begin
    int          in_idx;
    int          out_idx;
    logic        saw_low;
    logic        hv;
    logic        acc;
    logic [23:0] hm;
    logic [7:0]  he;

    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iMant  = '0;
    iExp   = '0;
    #3;
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_mant",  32'(oMant),  32'd0);
    chk("rst_exp",   32'(oExp),   32'd0);
    chk("rst_lzc",   32'(oLzc),   32'd0);
    chk("rst_zero",  32'(oZero),  32'd0);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk_unf("rst_unf", 1'b0);
    step();
    iRst = 1'b0;
    #1;
    chk("rel_ready", 32'(oReady), 32'd1);

    run_one("v100",  24'h000100, 8'd100, 24'h800000, 8'd85, 5'd15, 1'b0, 1'b0);
    run_one("vmsb",  24'h800000, 8'd7,   24'h800000, 8'd7,  5'd0,  1'b0, 1'b0);
    run_one("vzero", 24'h000000, 8'd50,  24'h000000, 8'd0,  5'd24, 1'b1, 1'b0);
    run_one("vedge", 24'h400000, 8'd1,   24'h800000, 8'd0,  5'd1,  1'b0, 1'b0);
`ifdef NORM_LZC_UNDERFLOW_EN
    run_one("vunf1", 24'h000001, 8'd10,  24'h000400, 8'd0,  5'd23, 1'b0, 1'b1);
    run_one("vunf2", 24'h0F0000, 8'd3,   24'h780000, 8'd0,  5'd4,  1'b0, 1'b1);
`else
    run_one("vunf1", 24'h000001, 8'd10,  24'h800000, 8'd243, 5'd23, 1'b0, 1'b0);
    run_one("vunf2", 24'h0F0000, 8'd3,   24'hF00000, 8'd255, 5'd4,  1'b0, 1'b0);
`endif

    // Six back-to-back items with iReady low during cycles 2..4.
    in_idx  = 0;
    out_idx = 0;
    saw_low = 1'b0;
    hv      = 1'b0;
    hm      = '0;
    he      = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
      iReady = !(cyc >= 2 && cyc <= 4);
      iValid = (in_idx < 6);
      iMant  = (in_idx < 6) ? in_m[in_idx] : '0;
      iExp   = (in_idx < 6) ? in_e[in_idx] : '0;
      @(negedge iClk);
      if (hv) begin
        chk("hold_valid", 32'(oValid), 32'd1);
        chk("hold_mant",  32'(oMant),  32'(hm));
        chk("hold_exp",   32'(oExp),   32'(he));
      end
      hv = oValid && !iReady;
      hm = oMant;
      he = oExp;
      if (!oReady) saw_low = 1'b1;
      if (oValid && iReady) begin
        chk("seq_mant", 32'(oMant), 32'(ex_m[out_idx]));
        chk("seq_exp",  32'(oExp),  32'(ex_e[out_idx]));
        chk("seq_lzc",  32'(oLzc),  32'(ex_l[out_idx]));
        out_idx++;
      end
      acc = iValid && oReady;
      step();
      if (acc) in_idx++;
    end
    iValid = 1'b0;
    iReady = 1'b1;
    chk("seq_ready_low", 32'(saw_low), 32'd1);
    chk("seq_count",     32'(out_idx), 32'd6);
    step();
    chk("seq_empty", 32'(oValid), 32'd0);

    // Reset with two items in flight.
    iValid = 1'b1;
    iMant  = 24'h000100;
    iExp   = 8'd100;
    step();
    iMant  = 24'h800000;
    iExp   = 8'd7;
    step();
    iValid = 1'b0;
    chk("mid_pre_valid", 32'(oValid), 32'd1);
    iRst = 1'b1;
    #1;
    chk("mid_valid", 32'(oValid), 32'd0);
    chk("mid_mant",  32'(oMant),  32'd0);
    chk("mid_lzc",   32'(oLzc),   32'd0);
    step();
    iRst = 1'b0;
    #1;
    chk("mid_ready", 32'(oReady), 32'd1);
    step();
    chk("mid_stale1", 32'(oValid), 32'd0);
    step();
    chk("mid_stale2", 32'(oValid), 32'd0);
    run_one("vpost", 24'h000100, 8'd100, 24'h800000, 8'd85, 5'd15, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/norm_lzc_pipe.md
NORM_LZC_PIPE -- requirements
Module: norm_lzc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24, mantissa width in bits (>=4).
REQ-002 SHALL have parameter EXP_W, default 8, exponent width in bits.
REQ-003 SHALL have local parameter CNT_W = $clog2(WIDTH+1), the leading-zero count width.
REQ-004 SHALL have port iClk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port iRst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port iValid  input  1  upstream data valid.
REQ-007 SHALL have port oReady  output  1  block can accept input this cycle.
REQ-008 SHALL have port iMant  input  WIDTH  unnormalised mantissa.
REQ-009 SHALL have port iExp  input  EXP_W  unbiased-agnostic exponent paired with iMant.
REQ-010 SHALL have port oValid  output  1  result valid.
REQ-011 SHALL have port iReady  input  1  downstream accepts result.
REQ-012 SHALL have port oMant  output  WIDTH  normalised mantissa, MSB set unless zero or underflow.
REQ-013 SHALL have port oExp  output  EXP_W  adjusted exponent.
REQ-014 SHALL have port oLzc  output  CNT_W  leading-zero count of accepted iMant.
REQ-015 SHALL have port oZero  output  1  accepted iMant was all zeros.

Function
REQ-016 SHALL accept input on a rising edge where iValid && oReady; a transfer out occurs where oValid && iReady.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers iMant, iExp and the leading-zero count; stage 2 registers the shifted mantissa, adjusted exponent, oLzc and oZero.
REQ-018 SHALL present a result on oValid exactly 2 cycles after acceptance when iReady is held high; throughput 1 result per cycle.
REQ-019 SHALL compute the count as a parametrised priority encode from MSB: number of zero bits above the highest set bit; all-zero input gives WIDTH.
REQ-020 SHALL output oMant = iMant << count (zero-filled) and oExp = iExp - count for non-zero input without underflow.
REQ-021 SHALL output oMant = 0, oExp = 0, oLzc = WIDTH and oZero = 1 for all-zero input; oZero = 0 otherwise.
REQ-022 SHALL advance stage 2 when !oValid || iReady, and stage 1 when stage 1 empty or stage 2 advances; oReady SHALL equal the stage 1 advance condition (combinational from iReady).
REQ-023 SHALL hold oValid, oMant, oExp, oLzc and oZero stable while oValid && !iReady.
REQ-024 SHALL neither drop, duplicate nor reorder items under any iValid/iReady pattern, including simultaneous accept and emit on a full pipeline.
REQ-025 SHALL ignore iMant/iExp when iValid is low; stage valid bits clear when a stage empties without refill.

Reset
REQ-026 SHALL, while iRst is high, asynchronously clear both stage valid bits and all data registers; oValid = 0, oMant = 0, oExp = 0, oLzc = 0, oZero = 0.
REQ-027 SHALL drive oReady = 1 during reset and on the first cycle after reset release.
REQ-028 SHALL discard in-flight items when iRst asserts mid-operation; no partial result emerges after release.

Configuration
REQ-029 SHALL, with macro NORM_LZC_UNDERFLOW_EN defined, add port oUnf  output  1  exponent underflow flag (reset 0).
REQ-030 SHALL, with NORM_LZC_UNDERFLOW_EN, for non-zero input with iExp < count, output oExp = 0, oMant = iMant << iExp, oUnf = 1; otherwise oUnf = 0.
REQ-031 SHALL, without NORM_LZC_UNDERFLOW_EN, omit oUnf and compute oExp = (iExp - count) mod 2^EXP_W with full shift by count.

Verification (WIDTH=24, EXP_W=8, iReady high unless stated)
REQ-032 SHALL cover: iMant=24'h000100, iExp=100 -> 2 cycles later oLzc=15, oMant=24'h800000, oExp=85, oZero=0.
REQ-033 SHALL cover: iMant=24'h800000, iExp=7 -> oLzc=0, oMant=24'h800000, oExp=7.
REQ-034 SHALL cover: iMant=0, iExp=50 -> oZero=1, oLzc=24, oMant=0, oExp=0.
REQ-035 SHALL cover: 6 back-to-back items, iReady low for 3 cycles after first oValid -> oReady drops when both stages full, all 6 emerge in order, outputs stable while stalled.
REQ-036 SHALL cover: iMant=24'h000001, iExp=10 -> with macro oUnf=1, oExp=0, oMant=24'h000400; without macro oExp=243, oMant=24'h800000.
REQ-037 SHALL cover: iRst pulsed with 2 items in flight -> oValid=0 immediately, no stale output after release, next item returns correct result.
